// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Holds the line/offset/address geometry, the line type, the refill
// FSM state encoding and a word-select helper used on the response path.
package icache_pkg;

  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  localparam int ADDR_W   = 32;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } refill_state_t;

  // Word 0 is bits 31:0 of the line.
  function automatic logic [31:0] line_word(input line_t line, input logic [1:0] sel);
    line_word = line[32*sel +: 32];
  endfunction

endpackage

// File: rtl/refill_timer.sv
// Timeout counter for the refill request phase.
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   i_clear       zero the count (refill request starting)
//   i_enable      one request cycle elapsed without memory data
//   o_expire      this enabled cycle is the last one allowed
// TIMEOUT = 0 disables expiry entirely.
module refill_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(LIMIT));
  assign o_expire   = (TIMEOUT != 0) && i_enable && w_at_limit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expire && (TIMEOUT != 0)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: accepts one miss at a time,
// requests the 16-byte line from memory, writes it into the cache array
// for one cycle, then returns the requested 32-bit word to the core.
// A request that waits too long for memory is abandoned with an err pulse.
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_miss_valid/i_miss_addr/o_miss_ready miss handshake from the core
//   o_mem_req/o_mem_addr                 line request (line-aligned address)
//   i_mem_ready/i_mem_data_in            memory returns the line
//   o_fill_valid/_index/_tag/_data       cache array write strobe and payload
//   o_resp_valid/o_resp_data             requested word back to the core
//   o_err                                one-cycle timeout pulse
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TIMEOUT = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_miss_valid,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  output logic                           o_miss_ready,
  output logic                           o_mem_req,
  output logic [ADDR_W-1:0]              o_mem_addr,
  input  logic                           i_mem_ready,
  input  logic [LINE_W-1:0]              i_mem_data_in,
  output logic                           o_fill_valid,
  output logic [INDEX_W-1:0]             o_fill_index,
  output logic [ADDR_W-OFFSET_W-INDEX_W-1:0] o_fill_tag,
  output logic [LINE_W-1:0]              o_fill_data,
  output logic                           o_resp_valid,
  output logic [31:0]                    o_resp_data,
  output logic                           o_err
);

  refill_state_t r_state;
  refill_state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  line_t             r_line;
  logic [31:0]       r_resp_data;
  logic              r_err;

  logic w_accept;
  logic w_capture;
  logic w_wait;
  logic w_expire;
  logic w_unused_addr;

  // Byte-within-word bits are never needed: requests and responses are word granular.
  assign w_unused_addr = ^r_addr[1:0];

  // Data arriving in the same cycle as the deadline wins over the timeout
  // because w_wait excludes i_mem_ready from the timer enable.
  assign w_capture = (r_state == REQ) && i_mem_ready;
  assign w_wait    = (r_state == REQ) && !i_mem_ready;

  refill_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_accept),
    .i_enable (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    o_miss_ready = 1'b0;
    o_mem_req    = 1'b0;
    o_fill_valid = 1'b0;
    o_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          w_next = FILL;
        end else if (w_expire) begin
          w_next = IDLE;
        end
      end
      FILL: begin
        o_fill_valid = 1'b1;
        w_next       = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        w_next       = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_line      <= '0;
      r_resp_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_wait && w_expire;
      if (w_accept) begin
        r_addr <= i_miss_addr;
      end
      if (w_capture) begin
        r_line <= i_mem_data_in;
      end
      // Response word is latched once so it holds across later misses.
      if (r_state == FILL) begin
        r_resp_data <= line_word(r_line, r_addr[3:2]);
      end
    end
  end

  assign o_mem_addr   = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign o_fill_index = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign o_fill_tag   = r_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign o_fill_data  = r_line;
  assign o_resp_data  = r_resp_data;
  assign o_err        = r_err;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl (INDEX_W=6, TIMEOUT=8).
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_data_in;
  logic         fill_valid;
  logic [5:0]   fill_index;
  logic [21:0]  fill_tag;
  logic [127:0] fill_data;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
  localparam logic [127:0] D3 = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
  localparam logic [127:0] D4 = 128'hCAFE0003_BEEF0002_FACE0001_F00D0000;

  icache_refill_ctrl #(
    .INDEX_W (6),
    .TIMEOUT (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_miss_valid  (miss_valid),
    .i_miss_addr   (miss_addr),
    .o_miss_ready  (miss_ready),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ready   (mem_ready),
    .i_mem_data_in (mem_data_in),
    .o_fill_valid  (fill_valid),
    .o_fill_index  (fill_index),
    .o_fill_tag    (fill_tag),
    .o_fill_data   (fill_data),
    .o_resp_valid  (resp_valid),
    .o_resp_data   (resp_data),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; mem_ready = 1'b0; mem_data_in = '0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_fill_data", fill_data, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_miss_ready", miss_ready, 1);

    // Long wait: mem_ready three cycles after acceptance
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A34;
    step();
    miss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("a_mem_req", mem_req, 1);
      chk("a_mem_addr", mem_addr, 32'h00FF_7A30);
      chk("a_miss_ready", miss_ready, 0);
      if (i == 2) begin mem_ready = 1'b1; mem_data_in = D1; end
      step();
    end
    mem_ready = 1'b0; mem_data_in = '0;
    chk("a_fill_valid", fill_valid, 1);
    chk("a_fill_index", fill_index, 6'h23);
    chk("a_fill_tag", fill_tag, 22'h003FDE);
    chk("a_fill_data", fill_data, D1);
    chk("a_mem_req_off", mem_req, 0);
    chk("a_resp_early", resp_valid, 0);
    step();
    chk("a_resp_valid", resp_valid, 1);
    chk("a_resp_data", resp_data, 32'h22222222);
    chk("a_fill_off", fill_valid, 0);
    step();
    chk("a_resp_off", resp_valid, 0);
    chk("a_resp_hold", resp_data, 32'h22222222);
    chk("a_idle_ready", miss_ready, 1);

    // Immediate data in the first request cycle
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A00;
    step();
    miss_valid = 1'b0;
    chk("b_mem_req", mem_req, 1);
    chk("b_mem_addr", mem_addr, 32'h00FF_7A00);
    mem_ready = 1'b1; mem_data_in = D2;
    step();
    mem_ready = 1'b0;
    chk("b_mem_req_off", mem_req, 0);
    chk("b_fill_valid", fill_valid, 1);
    chk("b_fill_index", fill_index, 6'h20);
    step();
    chk("b_resp_valid", resp_valid, 1);
    chk("b_resp_data", resp_data, 32'hAAAA0001);
    step();

    // Timeout: eight request cycles without data
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A34;
    step();
    miss_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("c_mem_req", mem_req, 1);
      chk("c_err_low", err, 0);
      step();
    end
    chk("c_err", err, 1);
    chk("c_mem_req_off", mem_req, 0);
    chk("c_miss_ready", miss_ready, 1);
    chk("c_fill_valid", fill_valid, 0);
    step();
    chk("c_err_pulse", err, 0);
    chk("c_resp_valid", resp_valid, 0);
    chk("c_fill_valid2", fill_valid, 0);

    // Data arrives in the deadline cycle
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A3C;
    step();
    miss_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("d_mem_req", mem_req, 1);
    mem_ready = 1'b1; mem_data_in = D2;
    step();
    mem_ready = 1'b0;
    chk("d_fill_valid", fill_valid, 1);
    chk("d_err0", err, 0);
    step();
    chk("d_resp_valid", resp_valid, 1);
    chk("d_resp_data", resp_data, 32'hDDDD0004);
    chk("d_err1", err, 0);
    step();
    chk("d_err2", err, 0);

    // Reset two cycles into a request, late mem_ready afterwards
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A34;
    step();
    miss_valid = 1'b0;
    step();
    chk("e_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("e_rst_mem_req", mem_req, 0);
    chk("e_rst_mem_addr", mem_addr, 0);
    chk("e_rst_fill_data", fill_data, 0);
    chk("e_rst_resp_data", resp_data, 0);
    step();
    rst = 1'b0;
    step();
    chk("e_miss_ready", miss_ready, 1);
    mem_ready = 1'b1; mem_data_in = D3;
    step();
    mem_ready = 1'b0;
    chk("e_fill_valid", fill_valid, 0);
    chk("e_mem_req_off", mem_req, 0);
    step();
    chk("e_resp_valid", resp_valid, 0);
    chk("e_fill_data", fill_data, 0);
    chk("e_err", err, 0);
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A04;
    step();
    miss_valid = 1'b0;
    chk("e_new_mem_addr", mem_addr, 32'h00FF_7A00);
    mem_ready = 1'b1; mem_data_in = D1;
    step();
    mem_ready = 1'b0;
    step();
    chk("e_new_resp_valid", resp_valid, 1);
    chk("e_new_resp_data", resp_data, 32'h22222222);
    step();

    // Back-to-back misses held by the core, spurious mem_ready in IDLE
    mem_ready = 1'b1; mem_data_in = D4;
    step();
    mem_ready = 1'b0;
    chk("f_spur_fill", fill_valid, 0);
    chk("f_spur_req", mem_req, 0);
    miss_valid = 1'b1; miss_addr = 32'h00FF_7A10;
    step();
    miss_addr = 32'h00FF_7AF8;
    chk("f1_mem_addr", mem_addr, 32'h00FF_7A10);
    chk("f1_busy", miss_ready, 0);
    mem_ready = 1'b1; mem_data_in = D3;
    step();
    mem_ready = 1'b0;
    chk("f1_fill_valid", fill_valid, 1);
    chk("f1_fill_index", fill_index, 6'h21);
    chk("f1_fill_data", fill_data, D3);
    step();
    chk("f1_resp_valid", resp_valid, 1);
    chk("f1_resp_data", resp_data, 32'h3C3C3C3C);
    step();
    chk("f_idle_ready", miss_ready, 1);
    mem_ready = 1'b1; mem_data_in = D1;
    step();
    mem_ready = 1'b0;
    miss_valid = 1'b0;
    chk("f2_mem_req", mem_req, 1);
    chk("f2_mem_addr", mem_addr, 32'h00FF_7AF0);
    step();
    chk("f2_mem_req_hold", mem_req, 1);
    chk("f2_no_fill", fill_valid, 0);
    mem_ready = 1'b1; mem_data_in = D4;
    step();
    mem_ready = 1'b0;
    chk("f2_fill_valid", fill_valid, 1);
    chk("f2_fill_index", fill_index, 6'h2F);
    chk("f2_fill_tag", fill_tag, 22'h003FDE);
    chk("f2_fill_data", fill_data, D4);
    step();
    chk("f2_resp_valid", resp_valid, 1);
    chk("f2_resp_data", resp_data, 32'hBEEF0002);
    step();
    chk("f2_idle", miss_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
